// File: rtl/adders_pkg.sv
// Shared definitions for the interchangeable adder implementations:
// default operand/block sizes and the common {Cout, Overflow, SUM} result record.
package adders_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ADDER_BLOCK = 4;

    typedef struct packed {
        logic                   cout;
        logic                   overflow;
        logic [ADDER_WIDTH-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/carry_skip_adder_if.sv
// Operand/result bundle for carry_skip_adder; the driver of operands is the
// master, the adder itself is the slave.
interface carry_skip_adder_if
    import adders_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
);

    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_overflow;

    modport master (
        output i_a, i_b, i_cin,
        input  o_sum, o_cout, o_overflow
    );

    modport slave (
        input  i_a, i_b, i_cin,
        output o_sum, o_cout, o_overflow
    );

endinterface

// File: rtl/carry_skip_block.sv
// One ripple block of the carry-skip adder: ripple full-adder chain, block
// propagate, bypass mux on the carry-out, and the carry into the block MSB.
module carry_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_prop,
    output logic             o_msb_carry
);

    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic             w_carry;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Ripple through the block; when every bit propagates, the carry-out is
    // taken straight from the block carry-in instead of the end of the chain.
    always_comb begin
        w_carry     = i_cin;
        o_sum       = '0;
        o_msb_carry = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            if (i == BLOCK - 1) begin
                o_msb_carry = w_carry;
            end
            o_sum[i] = w_p[i] ^ w_carry;
            w_carry  = w_g[i] | (w_p[i] & w_carry);
        end
        o_prop = &w_p;
        o_cout = o_prop ? i_cin : w_carry;
    end

endmodule

// File: rtl/carry_skip_adder.sv
// Registered carry-skip adder, latency 1; defining CSKA_IN_REG_EN adds an
// operand input register and raises the latency to 2.
module carry_skip_adder
    import adders_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLOCK = ADDER_BLOCK
) (
    input logic               clk,
    input logic               rst,
    carry_skip_adder_if.slave bus
);

    localparam int NBLK = WIDTH / BLOCK;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic [NBLK-1:0]  w_prop;
    logic [NBLK-1:0]  w_msb_carry;
    logic             w_chain_cout;
    logic             w_cout;
    logic             w_overflow;
    logic             w_unused_msb;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

`ifdef CSKA_IN_REG_EN
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= bus.i_a;
            r_b   <= bus.i_b;
            r_cin <= bus.i_cin;
        end
    end

    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = bus.i_a;
    assign w_b   = bus.i_b;
    assign w_cin = bus.i_cin;
`endif

    // Each block's carry lives in its own generate scope so the skip chain is
    // a plain chain of nets rather than one self-referencing vector.
    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic w_blk_cin;
        logic w_blk_cout;

        if (k == 0) begin : g_first
            assign w_blk_cin = w_cin;
        end else begin : g_next
            assign w_blk_cin = g_blk[k-1].w_blk_cout;
        end

        carry_skip_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .i_a         (w_a[k*BLOCK +: BLOCK]),
            .i_b         (w_b[k*BLOCK +: BLOCK]),
            .i_cin       (w_blk_cin),
            .o_sum       (w_sum[k*BLOCK +: BLOCK]),
            .o_cout      (w_blk_cout),
            .o_prop      (w_prop[k]),
            .o_msb_carry (w_msb_carry[k])
        );
    end

    assign w_chain_cout = g_blk[NBLK-1].w_blk_cout;

    // A word that propagates in every block skips the whole chain at once.
    assign w_cout       = (&w_prop) ? w_cin : w_chain_cout;
    assign w_overflow   = w_msb_carry[NBLK-1] ^ w_cout;
    assign w_unused_msb = ^w_msb_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sum      <= w_sum;
            r_cout     <= w_cout;
            r_overflow <= w_overflow;
        end
    end

    assign bus.o_sum      = r_sum;
    assign bus.o_cout     = r_cout;
    assign bus.o_overflow = r_overflow;

endmodule

// File: tb/tb_carry_skip_adder.sv
// Self-checking bench for carry_skip_adder; expected latency follows the
// CSKA_IN_REG_EN macro so the same bench covers both builds.
module tb_carry_skip_adder;
    import adders_pkg::*;

`ifdef CSKA_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        string         name;
        logic [31:0]   a;
        logic [31:0]   b;
        logic          cin;
        adder_result_t exp;
    } vec_t;

    typedef struct {
        string         name;
        adder_result_t exp;
        int            due;
    } sb_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   edgeCnt;
    sb_t  sbq[$];
    vec_t vecs[9];

    carry_skip_adder_if #(.WIDTH(32)) bus ();

    carry_skip_adder #(
        .WIDTH(32),
        .BLOCK(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic adder_result_t mkRes(input logic cout, input logic ovf, input logic [31:0] sum);
        adder_result_t r;
        r.cout     = cout;
        r.overflow = ovf;
        r.sum      = sum;
        return r;
    endfunction

    function automatic vec_t mkVec(input string name, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic cout, input logic ovf,
                                   input logic [31:0] sum);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.exp  = mkRes(cout, ovf, sum);
        return v;
    endfunction

    // Reference: 33-bit unsigned sum, overflow from operand/result signs.
    function automatic adder_result_t refModel(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0]   full;
        adder_result_t r;
        full       = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        r.sum      = full[31:0];
        r.cout     = full[32];
        r.overflow = (a[31] == b[31]) && (r.sum[31] != a[31]);
        return r;
    endfunction

    task automatic checkOutput(input string name, input adder_result_t exp);
        adder_result_t act;
        act.cout     = bus.o_cout;
        act.overflow = bus.o_overflow;
        act.sum      = bus.o_sum;
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got cout=%0b ovf=%0b sum=%h, expected cout=%0b ovf=%0b sum=%h",
                     name, act.cout, act.overflow, act.sum, exp.cout, exp.overflow, exp.sum);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input adder_result_t exp);
        sb_t e;
        bus.i_a   = a;
        bus.i_b   = b;
        bus.i_cin = cin;
        e.name    = name;
        e.exp     = exp;
        e.due     = edgeCnt + LAT;
        sbq.push_back(e);
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        edgeCnt++;
        while (sbq.size() > 0 && sbq[0].due <= edgeCnt) begin
            e = sbq.pop_front();
            checkOutput(e.name, e.exp);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < LAT + 3 && sbq.size() > 0; i++) begin
            tick();
        end
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s: %0d results still pending, expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        adder_result_t r;
        logic [31:0]   ra;
        logic [31:0]   rb;
        logic          rc;

        compared   = 0;
        mismatched = 0;
        edgeCnt    = 0;

        vecs[0] = mkVec("10+15",        32'd10,       32'd15,       1'b0, 1'b0, 1'b0, 32'd25);
        vecs[1] = mkVec("minneg+minneg", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h00000000);
        vecs[2] = mkVec("maxpos+maxpos", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
        vecs[3] = mkVec("10+-10",       32'd10,       32'hFFFFFFF6, 1'b0, 1'b1, 1'b0, 32'h00000000);
        vecs[4] = mkVec("fullprop",     32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
        vecs[5] = mkVec("skipchain",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h00000000);
        vecs[6] = mkVec("0+0+cin",      32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000001);
        vecs[7] = mkVec("maxpos+1",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000);
        vecs[8] = mkVec("-1+-1+cin",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);

        // Reset with live operands on the bus: reset must win.
        rst       = 1'b1;
        bus.i_a   = 32'h7FFFFFFF;
        bus.i_b   = 32'h7FFFFFFF;
        bus.i_cin = 1'b1;
        tick();
        tick();
        checkOutput("reset_state", mkRes(1'b0, 1'b0, 32'h0));
        rst = 1'b0;

        // Directed vectors, back to back at full throughput.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
            tick();
        end
        drain("table_drain");

        // Mid-stream reset: in-flight result and the operand presented at the
        // reset edge are both discarded.
        applyStimulus("pre_reset", 32'hFFFFFFFF, 32'h00000000, 1'b1, mkRes(1'b1, 1'b0, 32'h0));
        tick();
        bus.i_a   = 32'h12345678;
        bus.i_b   = 32'h11111111;
        bus.i_cin = 1'b1;
        rst       = 1'b1;
        sbq.delete();
        tick();
        checkOutput("mid_reset", mkRes(1'b0, 1'b0, 32'h0));
        rst = 1'b0;
        applyStimulus("post_reset", 32'd10, 32'd15, 1'b0, mkRes(1'b0, 1'b0, 32'd25));
        tick();
        bus.i_a   = 32'h0;
        bus.i_b   = 32'h0;
        bus.i_cin = 1'b0;
        drain("reset_drain");

        // Random operands against the reference model.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            r  = refModel(ra, rb, rc);
            applyStimulus("random", ra, rb, rc, r);
            tick();
        end
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
